// File: rtl/seq_shift_unit.sv
// ---------------------------------------------------------------------------
// seq_shift_unit
//
// Sequential shift/rotate unit. An accepted start captures the operand, the
// shift amount, the direction and the mode. The unit then moves the working
// register one bit position per clock until the captured count reaches zero.
// On the following edge it publishes the working register on result and
// raises done for one cycle. The published result feeds the per-bit digit
// outputs of the display path.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      operation request, sampled only while idle
//   direction  in   1      1 = shift/rotate left, 0 = right
//   mode       in   2      00 logical, 01 arithmetic, 10 rotate, 11 logical
//   X          in   WIDTH  operand, captured on the accepting edge
//   shamt      in   SHW    shift amount, captured on the accepting edge
//   busy       out  1      operation in progress
//   done       out  1      one-cycle completion pulse
//   result     out  WIDTH  last completed result, held between done pulses
// ---------------------------------------------------------------------------
module seq_shift_unit #(
    parameter int WIDTH = 6,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             direction,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] X,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_ARITH  = 2'b01;
    localparam logic [1:0] MODE_ROTATE = 2'b10;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [SHW-1:0]   cnt_q,    cnt_d;
    logic             dir_q,    dir_d;
    logic [1:0]       mode_q,   mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // One-position move of the working register. Arithmetic left behaves as
    // logical left; mode 11 falls through to logical.
    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] w,
        input logic             left,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        case (m)
            MODE_ROTATE: begin
                if (left) begin
                    r = {w[WIDTH-2:0], w[WIDTH-1]};
                end else begin
                    r = {w[0], w[WIDTH-1:1]};
                end
            end
            MODE_ARITH: begin
                if (left) begin
                    r = {w[WIDTH-2:0], 1'b0};
                end else begin
                    // Sign fill: the MSB held before the move is replicated.
                    r = {w[WIDTH-1], w[WIDTH-1:1]};
                end
            end
            default: begin
                if (left) begin
                    r = {w[WIDTH-2:0], 1'b0};
                end else begin
                    r = {1'b0, w[WIDTH-1:1]};
                end
            end
        endcase
        return r;
    endfunction

    // Next-state and next-output logic for the IDLE/SHIFT controller.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        mode_d   = mode_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = X;
                    cnt_d   = shamt;
                    dir_d   = direction;
                    mode_d  = mode;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                // start is deliberately not looked at here: no queueing.
                if (cnt_q != {SHW{1'b0}}) begin
                    work_d = shift_one(work_q, dir_q, mode_q);
                    cnt_d  = cnt_q - SHW'(1);
                end else begin
                    result_d = work_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            work_q   <= {WIDTH{1'b0}};
            cnt_q    <= {SHW{1'b0}};
            dir_q    <= 1'b0;
            mode_q   <= 2'b00;
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// ---------------------------------------------------------------------------
// tb_seq_shift_unit
//
// Directed and randomized stimulus for seq_shift_unit (WIDTH=6, SHW=3).
// Expected results come from an arithmetic reference model of the shift
// rules. Expected timing comes from the shamt+1 latency rule.
// ---------------------------------------------------------------------------
module tb_seq_shift_unit;

    localparam int W = 6;
    localparam int S = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         direction;
    logic [1:0]   mode;
    logic [W-1:0] X;
    logic [S-1:0] shamt;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] res_prev;

    seq_shift_unit #(.WIDTH(W), .SHW(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .direction (direction),
        .mode      (mode),
        .X         (X),
        .shamt     (shamt),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: whole-operation result from plain integer arithmetic.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input bit left,
                                           input logic [1:0] m, input int s);
        int mask = (1 << W) - 1;
        int v    = int'(x);
        int r;
        if (m == 2'b10) begin
            r = s % W;
            if (r == 0) return x;
            if (left) return W'(((v << r) | (v >> (W - r))) & mask);
            return W'(((v >> r) | (v << (W - r))) & mask);
        end
        if (left) return (s >= W) ? '0 : W'((v << s) & mask);
        if (m == 2'b01) begin
            if (x[W-1]) v = v - (1 << W);
            return W'((v >>> s) & mask);
        end
        return W'(v >> s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start an operation at the next edge, then check every cycle through done.
    task automatic run_op(input string tag, input logic [W-1:0] x, input bit left,
                          input logic [1:0] m, input logic [S-1:0] s,
                          input logic [W-1:0] exp);
        @(negedge clk);
        start = 1'b1; X = x; direction = left; mode = m; shamt = s;
        @(posedge clk); #1;                               // E0
        start = 1'b0;
        X = W'($urandom); shamt = S'($urandom); direction = 1'($urandom); mode = 2'($urandom);
        chk({tag, "_busy_E0"}, busy, 1'b1);
        chk({tag, "_done_E0"}, done, 1'b0);
        for (int k = 1; k <= int'(s); k++) begin
            @(posedge clk); #1;
            chk({tag, "_busy_mid"}, busy, 1'b1);
            chk({tag, "_done_mid"}, done, 1'b0);
            chk({tag, "_res_held"}, result, res_prev);
        end
        @(posedge clk); #1;                               // E(s+1)
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_result"}, result, exp);
        res_prev = exp;
    endtask

    task automatic idle_cycle(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, done, 1'b0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
        chk({tag, "_res_hold"}, result, res_prev);
    endtask

    initial begin
        logic [W-1:0] xa;
        logic [W-1:0] xr;
        logic [1:0]   mr;
        logic [S-1:0] sr;
        bit           dr;

        rst_n = 1'b0; start = 1'b0; direction = 1'b0; mode = 2'b00;
        X = '0; shamt = '0; res_prev = '0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 6'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed cases
        run_op("t1", 6'b101101, 1'b1, 2'b00, 3'd2, 6'b110100); idle_cycle("t1");
        run_op("t2", 6'b100110, 1'b0, 2'b01, 3'd3, 6'b111100); idle_cycle("t2");
        run_op("t3a", 6'b000111, 1'b0, 2'b10, 3'd2, 6'b110001); idle_cycle("t3a");
        run_op("t3b", 6'b000111, 1'b1, 2'b10, 3'd7, 6'b001110); idle_cycle("t3b");
        run_op("t4a", 6'b101010, 1'b1, 2'b00, 3'd0, 6'b101010); idle_cycle("t4a");
        run_op("t4b", 6'b101010, 1'b0, 2'b00, 3'd7, 6'b000000); idle_cycle("t4b");
        run_op("ar7", 6'b100001, 1'b0, 2'b01, 3'd7, 6'b111111); idle_cycle("ar7");
        // start held high during the done cycle is accepted immediately
        run_op("bb1", 6'b110001, 1'b1, 2'b11, 3'd1, 6'b100010);
        run_op("bb2", 6'b010110, 1'b0, 2'b10, 3'd1, 6'b001011); idle_cycle("bb2");

        // Test 5: second start while busy is ignored
        xa = 6'b110011;
        @(negedge clk);
        start = 1'b1; X = xa; direction = 1'b1; mode = 2'b00; shamt = 3'd5;
        @(posedge clk); #1;                               // E0
        start = 1'b0;
        chk("t5_busy_E0", busy, 1'b1);
        @(posedge clk); #1;                               // E1
        start = 1'b1; X = 6'b000001; direction = 1'b0; mode = 2'b10; shamt = 3'd1;
        @(posedge clk); #1;                               // E2
        start = 1'b0;
        for (int e = 3; e <= 5; e++) begin
            @(posedge clk); #1;
            chk("t5_busy_mid", busy, 1'b1);
            chk("t5_done_mid", done, 1'b0);
        end
        @(posedge clk); #1;                               // E6
        chk("t5_done", done, 1'b1);
        chk("t5_result", result, model(xa, 1'b1, 2'b00, 5));
        res_prev = model(xa, 1'b1, 2'b00, 5);
        idle_cycle("t5");

        // Test 6: asynchronous reset in the middle of SHIFT
        @(negedge clk);
        start = 1'b1; X = 6'b011011; direction = 1'b0; mode = 2'b01; shamt = 3'd5;
        @(posedge clk); #1; start = 1'b0;                 // E0
        @(posedge clk); #1;                               // E1
        @(posedge clk); #1;                               // E2
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_done", done, 1'b0);
        chk("t6_rst_result", result, 6'd0);
        res_prev = '0;
        @(negedge clk); rst_n = 1'b1;
        run_op("t6_after", 6'b011011, 1'b0, 2'b01, 3'd2, 6'b000110); idle_cycle("t6_after");

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            xr = W'($urandom); mr = 2'($urandom); sr = S'($urandom); dr = 1'($urandom);
            run_op("rnd", xr, dr, mr, sr, model(xr, dr, mr, int'(sr)));
            if ($urandom_range(0, 1) == 0) idle_cycle("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
